// File: rtl/src_operand_buf_pkg.sv
// rtl/src_operand_buf_pkg.sv - shared types for the source operand skid buffer
package src_operand_buf_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        SB_EMPTY,
        SB_ONE,
        SB_FULL
    } src_buf_state_t;

    typedef struct packed {
        data_t      src1;
        data_t      src2;
        data_t      src3;
        logic [4:0] sel_wb;
    } src_bundle_t;

endpackage

// File: rtl/src_operand_buf.sv
// rtl/src_operand_buf.sv - two-entry skid buffer between PathSel and the vector exec unit
// Optional stall-cycle counter enabled by defining SRC_BUF_PERF_CNT_EN.
module src_operand_buf
    import src_operand_buf_pkg::*;
#(
    parameter int LANE_ID   = 0,
    parameter int TAG_WIDTH = 7,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Flush,
    input  logic                 I_Req,
    input  data_t                I_Src_Data1,
    input  data_t                I_Src_Data2,
    input  data_t                I_Src_Data3,
    input  logic [4:0]           I_Sel_Path_WB,
    input  logic [TAG_WIDTH-1:0] I_Tag,
    output logic                 O_Stall,
    output logic                 O_Req,
    input  logic                 I_Stall,
    output data_t                O_Src_Data1,
    output data_t                O_Src_Data2,
    output data_t                O_Src_Data3,
    output logic [4:0]           O_Sel_Path_WB,
    output logic [TAG_WIDTH-1:0] O_Tag
`ifdef SRC_BUF_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] O_Stall_Cnt
`endif
);

    src_buf_state_t         state_q;
    src_bundle_t            head_q;
    src_bundle_t            skid_q;
    logic [TAG_WIDTH-1:0]   head_tag_q;
    logic [TAG_WIDTH-1:0]   skid_tag_q;
    logic                   req_q;
    logic                   stall_q;

    src_bundle_t            in_bundle;
    logic                   push;
    logic                   pop;

    assign in_bundle = '{src1: I_Src_Data1, src2: I_Src_Data2, src3: I_Src_Data3, sel_wb: I_Sel_Path_WB};

    // Both handshakes use only registered outputs, so I_Stall never reaches O_Stall combinationally.
    assign push = I_Req & ~stall_q;
    assign pop  = req_q & ~I_Stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= SB_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            head_tag_q <= '0;
            skid_tag_q <= '0;
            req_q      <= 1'b0;
            stall_q    <= 1'b0;
        end else if (I_Flush) begin
            state_q    <= SB_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            head_tag_q <= '0;
            skid_tag_q <= '0;
            req_q      <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            case (state_q)
                SB_EMPTY: begin
                    if (push) begin
                        head_q     <= in_bundle;
                        head_tag_q <= I_Tag;
                        req_q      <= 1'b1;
                        state_q    <= SB_ONE;
                    end
                end
                SB_ONE: begin
                    if (push && pop) begin
                        head_q     <= in_bundle;
                        head_tag_q <= I_Tag;
                    end else if (push) begin
                        skid_q     <= in_bundle;
                        skid_tag_q <= I_Tag;
                        stall_q    <= 1'b1;
                        state_q    <= SB_FULL;
                    end else if (pop) begin
                        req_q      <= 1'b0;
                        state_q    <= SB_EMPTY;
                    end
                end
                SB_FULL: begin
                    if (pop) begin
                        head_q     <= skid_q;
                        head_tag_q <= skid_tag_q;
                        stall_q    <= 1'b0;
                        state_q    <= SB_ONE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    stall_q <= 1'b0;
                    state_q <= SB_EMPTY;
                end
            endcase
        end
    end

    assign O_Req         = req_q;
    assign O_Stall       = stall_q;
    assign O_Src_Data1   = head_q.src1;
    assign O_Src_Data2   = head_q.src2;
    assign O_Src_Data3   = head_q.src3;
    assign O_Sel_Path_WB = head_q.sel_wb;
    assign O_Tag         = head_tag_q;

`ifdef SRC_BUF_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    // Flush deliberately leaves the count alone; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if ((stall_q | (req_q & I_Stall)) && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign O_Stall_Cnt = stall_cnt_q;
`endif

    a_no_req_while_stalled: assert property (@(posedge clock) disable iff (!reset) !(I_Req && O_Stall))
        else $warning("src_operand_buf lane %0d: I_Req ignored while O_Stall", LANE_ID);

endmodule

// File: tb/tb_src_operand_buf.sv
// tb/tb_src_operand_buf.sv - queue-model bench for src_operand_buf (covers SRC_BUF_PERF_CNT_EN when defined)
module tb_src_operand_buf;
    import src_operand_buf_pkg::*;

    localparam int TW = 7;
    localparam int CW = 8;

    typedef struct packed {
        data_t          d1;
        data_t          d2;
        data_t          d3;
        logic [4:0]     sel;
        logic [TW-1:0]  tag;
    } ent_t;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           flush = 1'b0;
    logic           req = 1'b0;
    logic           istall = 1'b0;
    ent_t           din = '0;
    logic           o_stall, o_req;
    data_t          o_d1, o_d2, o_d3;
    logic [4:0]     o_sel;
    logic [TW-1:0]  o_tag;
`ifdef SRC_BUF_PERF_CNT_EN
    logic [CW-1:0]  o_cnt;
`endif

    src_operand_buf #(.LANE_ID(0), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clock         (clock),
        .reset         (reset),
        .I_Flush       (flush),
        .I_Req         (req),
        .I_Src_Data1   (din.d1),
        .I_Src_Data2   (din.d2),
        .I_Src_Data3   (din.d3),
        .I_Sel_Path_WB (din.sel),
        .I_Tag         (din.tag),
        .O_Stall       (o_stall),
        .O_Req         (o_req),
        .I_Stall       (istall),
        .O_Src_Data1   (o_d1),
        .O_Src_Data2   (o_d2),
        .O_Src_Data3   (o_d3),
        .O_Sel_Path_WB (o_sel),
        .O_Tag         (o_tag)
`ifdef SRC_BUF_PERF_CNT_EN
        ,
        .O_Stall_Cnt   (o_cnt)
`endif
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    ent_t        q[$];
    ent_t        last_head = '0;
    int unsigned cnt_m = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t rnd();
        ent_t r;
        r.d1  = $urandom;
        r.d2  = $urandom;
        r.d3  = $urandom;
        r.sel = 5'($urandom);
        r.tag = TW'($urandom);
        return r;
    endfunction

    function automatic ent_t head_obs();
        return {o_d1, o_d2, o_d3, o_sel, o_tag};
    endfunction

    task automatic check_outputs();
        chk("o_req", o_req, q.size() != 0);
        chk("o_stall", o_stall, q.size() == 2);
        chk("head", head_obs(), last_head);
`ifdef SRC_BUF_PERF_CNT_EN
        chk("stall_cnt", o_cnt, cnt_m);
`endif
    endtask

    // Model works on the FIFO contents: at most two bundles, stall means two held.
    task automatic cycle();
        bit   m_full, push, pop, cinc;
        ent_t junk;
        m_full = (q.size() == 2);
        push   = req && !m_full;
        pop    = (q.size() != 0) && !istall;
        cinc   = m_full || ((q.size() != 0) && istall);
        @(posedge clock);
        #1;
        if (cinc && cnt_m < (2**CW - 1)) cnt_m++;
        if (flush) begin
            q.delete();
            last_head = '0;
        end else begin
            if (pop) junk = q.pop_front();
            if (push) q.push_back(din);
            if (q.size() != 0) last_head = q[0];
        end
        check_outputs();
    endtask

    task automatic drain();
        req = 1'b0; istall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
    endtask

    task automatic fill(output ent_t a, output ent_t b);
        a = rnd(); b = rnd();
        istall = 1'b0; req = 1'b1; din = a; cycle();
        istall = 1'b1; din = b; cycle();
        req = 1'b0;
    endtask

    ent_t A, B, C, D, E;

    initial begin
        #12;
        chk("rst_req", o_req, 1'b0);
        chk("rst_stall", o_stall, 1'b0);
        chk("rst_head", head_obs(), '0);
`ifdef SRC_BUF_PERF_CNT_EN
        chk("rst_cnt", o_cnt, '0);
`endif
        @(negedge clock);
        reset = 1'b1;

        // Streaming
        A = rnd(); B = rnd(); C = rnd();
        req = 1'b1;
        din = A; cycle(); chk("t1_a", head_obs(), A);
        din = B; cycle(); chk("t1_b", head_obs(), B);
        din = C; cycle(); chk("t1_c", head_obs(), C); chk("t1_nostall", o_stall, 1'b0);
        drain();

        // Skid
        fill(A, B);
        chk("t2_stall", o_stall, 1'b1); chk("t2_head_a", head_obs(), A);
        cycle();
        istall = 1'b0; cycle();
        chk("t2_head_b", head_obs(), B); chk("t2_unstall", o_stall, 1'b0);
        drain();

        // Hold while full with upstream holding C
        fill(A, B);
        C = rnd(); req = 1'b1; din = C;
        for (int i = 0; i < 10; i++) cycle();
        chk("t3_hold_a", head_obs(), A);
        istall = 1'b0; cycle(); chk("t3_b", head_obs(), B);
        cycle(); chk("t3_c", head_obs(), C);
        req = 1'b0; cycle(); chk("t3_empty", o_req, 1'b0);
        drain();

        // Flush with a concurrent push
        fill(A, B);
        D = rnd(); flush = 1'b1; req = 1'b1; din = D; istall = 1'b0; cycle();
        chk("t4_req", o_req, 1'b0); chk("t4_stall", o_stall, 1'b0); chk("t4_head", head_obs(), '0);
        flush = 1'b0; req = 1'b0;
        cycle(); chk("t4_no_d", o_req, 1'b0);

        // Async reset between edges while full
        fill(A, B);
        #3 reset = 1'b0;
        #1;
        chk("t5_req", o_req, 1'b0); chk("t5_stall", o_stall, 1'b0); chk("t5_head", head_obs(), '0);
`ifdef SRC_BUF_PERF_CNT_EN
        chk("t5_cnt", o_cnt, '0);
`endif
        q.delete(); last_head = '0; cnt_m = 0;
        #2 reset = 1'b1;
        E = rnd(); req = 1'b1; din = E; istall = 1'b0; cycle();
        chk("t5_e", head_obs(), E); chk("t5_e_req", o_req, 1'b1);
        drain();

`ifdef SRC_BUF_PERF_CNT_EN
        // Long stall to reach counter saturation, then flush must not clear it
        fill(A, B);
        for (int i = 0; i < 300; i++) cycle();
        chk("t6_sat", o_cnt, {CW{1'b1}});
        flush = 1'b1; cycle(); flush = 1'b0;
        chk("t6_flush_keep", o_cnt, {CW{1'b1}});
        drain();
`endif

        // Randomized traffic with a well-behaved upstream
        for (int i = 0; i < 2000; i++) begin
            flush  = ($urandom_range(0, 39) == 0);
            req    = (q.size() != 2) && ($urandom_range(0, 3) != 0);
            istall = ($urandom_range(0, 2) == 0);
            din    = rnd();
            cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
